// File: rtl/vga_pkg.sv
// Shared types and default geometry for the rectangle-fill engine.
package vga_pkg;

  localparam int HD      = 1280;
  localparam int VD      = 1024;
  localparam int COORD_W = 11;

  typedef enum logic [1:0] {
    BLACK = 2'd0,
    WHITE = 2'd1,
    BLUE  = 2'd2,
    GREEN = 2'd3
  } color_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    FILL  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/vga_rect_clip.sv
// Corner normalisation and screen clipping for one rectangle command.
module vga_rect_clip #(
  parameter int HD      = vga_pkg::HD,
  parameter int VD      = vga_pkg::VD,
  parameter int COORD_W = vga_pkg::COORD_W
) (
  input  logic               clear_i,
  input  logic [COORD_W-1:0] x0_i,
  input  logic [COORD_W-1:0] y0_i,
  input  logic [COORD_W-1:0] x1_i,
  input  logic [COORD_W-1:0] y1_i,
  output logic [COORD_W-1:0] xmin_o,
  output logic [COORD_W-1:0] xmax_o,
  output logic [COORD_W-1:0] ymin_o,
  output logic [COORD_W-1:0] ymax_o,
  output logic               empty_o
);

  localparam logic [COORD_W-1:0] XLAST = COORD_W'(HD - 1);
  localparam logic [COORD_W-1:0] YLAST = COORD_W'(VD - 1);

  logic [COORD_W-1:0] xlo, xhi, ylo, yhi;

  // Order the corners, clip the far edges, flag rectangles that start off-screen.
  always_comb begin
    xlo     = (x0_i < x1_i) ? x0_i : x1_i;
    xhi     = (x0_i < x1_i) ? x1_i : x0_i;
    ylo     = (y0_i < y1_i) ? y0_i : y1_i;
    yhi     = (y0_i < y1_i) ? y1_i : y0_i;
    xmin_o  = xlo;
    ymin_o  = ylo;
    xmax_o  = (int'(xhi) > HD - 1) ? XLAST : xhi;
    ymax_o  = (int'(yhi) > VD - 1) ? YLAST : yhi;
    empty_o = (int'(xlo) >= HD) || (int'(ylo) >= VD);
    if (clear_i) begin
      xmin_o  = '0;
      xmax_o  = XLAST;
      ymin_o  = '0;
      ymax_o  = YLAST;
      empty_o = 1'b0;
    end
  end

endmodule

// File: rtl/vga_rect_fill.sv
// Rectangle fill engine: accepts a command, then streams raster-ordered pixel writes.
module vga_rect_fill #(
  parameter int HD      = vga_pkg::HD,
  parameter int VD      = vga_pkg::VD,
  parameter int COORD_W = vga_pkg::COORD_W
) (
  input  logic               clk_i,
  input  logic               arst_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic               cmd_clear_i,
  input  logic [COORD_W-1:0] cmd_x0_i,
  input  logic [COORD_W-1:0] cmd_y0_i,
  input  logic [COORD_W-1:0] cmd_x1_i,
  input  logic [COORD_W-1:0] cmd_y1_i,
  input  logic [1:0]         cmd_color_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               we_o,
  output logic [COORD_W-1:0] addr_x_o,
  output logic [COORD_W-1:0] addr_y_o,
  output logic [1:0]         color_o
);

  import vga_pkg::*;

  state_t             state_q, state_d;
  logic               done_q, done_d;
  logic               we_q, we_d;
  logic [COORD_W-1:0] addr_x_q, addr_x_d, addr_y_q, addr_y_d;
  color_t             color_q, color_d;

  logic               clear_q;
  logic [COORD_W-1:0] x0_q, y0_q, x1_q, y1_q;
  color_t             cmd_color_q;

  logic [COORD_W-1:0] xmin_c, xmax_c, ymin_c, ymax_c;
  logic               empty_c;
  logic [COORD_W-1:0] xmin_q, xmax_q, ymax_q;
  logic [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
  logic               accept;

  assign accept = cmd_valid_i && (state_q == IDLE);

  vga_rect_clip #(
    .HD      (HD),
    .VD      (VD),
    .COORD_W (COORD_W)
  ) u_clip (
    .clear_i (clear_q),
    .x0_i    (x0_q),
    .y0_i    (y0_q),
    .x1_i    (x1_q),
    .y1_i    (y1_q),
    .xmin_o  (xmin_c),
    .xmax_o  (xmax_c),
    .ymin_o  (ymin_c),
    .ymax_o  (ymax_c),
    .empty_o (empty_c)
  );

  // Next state, raster counter stepping and registered pixel outputs.
  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    we_d     = 1'b0;
    addr_x_d = addr_x_q;
    addr_y_d = addr_y_q;
    color_d  = color_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) state_d = SETUP;
      end
      SETUP: begin
        cx_d    = xmin_c;
        cy_d    = ymin_c;
        state_d = empty_c ? DONE : FILL;
      end
      FILL: begin
        // The write issued on this edge is visible during the next cycle.
        we_d     = 1'b1;
        addr_x_d = cx_q;
        addr_y_d = cy_q;
        color_d  = cmd_color_q;
        if (cx_q == xmax_q) begin
          if (cy_q == ymax_q) begin
            state_d = DONE;
          end else begin
            cx_d = xmin_q;
            cy_d = cy_q + COORD_W'(1);
          end
        end else begin
          cx_d = cx_q + COORD_W'(1);
        end
      end
      DONE: begin
        // First DONE cycle lets the last write drain; the second carries the pulse.
        if (done_q) state_d = IDLE;
        else        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state and outputs, cleared immediately on reset.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q  <= IDLE;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_x_q <= '0;
      addr_y_q <= '0;
      color_q  <= BLACK;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      we_q     <= we_d;
      addr_x_q <= addr_x_d;
      addr_y_q <= addr_y_d;
      color_q  <= color_d;
    end
  end

  // Command capture, bound registers and raster counters.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      clear_q     <= cmd_clear_i;
      x0_q        <= cmd_x0_i;
      y0_q        <= cmd_y0_i;
      x1_q        <= cmd_x1_i;
      y1_q        <= cmd_y1_i;
      cmd_color_q <= color_t'(cmd_color_i);
    end
    if (state_q == SETUP) begin
      xmin_q <= xmin_c;
      xmax_q <= xmax_c;
      ymax_q <= ymax_c;
    end
    cx_q <= cx_d;
    cy_q <= cy_d;
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign we_o        = we_q;
  assign addr_x_o    = addr_x_q;
  assign addr_y_o    = addr_y_q;
  assign color_o     = color_q;

endmodule
